// File: rtl/mc_control_fsm_pkg.sv
// Shared encodings for the multi-cycle MIPS control sequencer: states,
// opcode/funct values, select codes and the packed control vector.
package mc_control_fsm_pkg;

    typedef enum logic [2:0] {
        ST_IF  = 3'd0,
        ST_ID  = 3'd1,
        ST_EX  = 3'd2,
        ST_MEM = 3'd3,
        ST_WB  = 3'd4,
        ST_ERR = 3'd5
    } state_t;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes (IR[5:0]); 0x20-0x27 form the plain ALU group
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    // ALUOp codes
    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;
    localparam logic [2:0] ALU_AND   = 3'b011;
    localparam logic [2:0] ALU_SLT   = 3'b100;
    localparam logic [2:0] ALU_SLTU  = 3'b101;

    // PCSource
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_REG    = 2'b11;

    // ALUSrcA / ALUSrcB
    localparam logic [1:0] SRCA_PC     = 2'b00;
    localparam logic [1:0] SRCA_REG    = 2'b01;
    localparam logic [1:0] SRCA_SHAMT  = 2'b10;
    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    // RegDst / MemtoReg
    localparam logic [1:0] DST_RD     = 2'b00;
    localparam logic [1:0] DST_RT     = 2'b01;
    localparam logic [1:0] DST_RA     = 2'b10;
    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       ior_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       ext_op;
        logic       lu_op;
        logic       retire;
    } ctrl_t;

    // True for every opcode/funct pair the sequencer knows how to execute.
    function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
        logic ok;
        ok = 1'b0;
        case (op)
            OP_RTYPE: ok = (fn == FN_SLL) || (fn == FN_SRL) || (fn == FN_SRA) ||
                           (fn == FN_JR) || (fn == FN_JALR) || (fn[5:3] == 3'b100) ||
                           (fn == FN_SLT) || (fn == FN_SLTU);
            OP_J, OP_JAL, OP_BEQ, OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_ANDI, OP_LUI, OP_LW, OP_SW: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic is_shift(input logic [5:0] fn);
        return (fn == FN_SLL) || (fn == FN_SRL) || (fn == FN_SRA);
    endfunction

endpackage

// File: rtl/mc_control_fsm_if.sv
// Datapath-facing bundle of the sequencer: instruction fields and memory
// handshake in, mux selects / write enables / status out.
// Handshake: in IF and MEM the request (MemRead or MemWrite) stays high and the
// state holds until a cycle with mem_ready=1; that cycle completes the access.
interface mc_control_fsm_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       PCWrite;
    logic       PCWriteCond;
    logic [1:0] PCSource;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic [1:0] RegDst;
    logic [1:0] MemtoReg;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUOp;
    logic       ExtOp;
    logic       LuOp;
    logic       retire;
    logic       illegal;
    logic       bus_err;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output PCWrite, PCWriteCond, PCSource, IorD, MemRead, MemWrite, IRWrite,
               RegWrite, RegDst, MemtoReg, ALUSrcA, ALUSrcB, ALUOp, ExtOp, LuOp,
               retire, illegal, bus_err
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  PCWrite, PCWriteCond, PCSource, IorD, MemRead, MemWrite, IRWrite,
               RegWrite, RegDst, MemtoReg, ALUSrcA, ALUSrcB, ALUOp, ExtOp, LuOp,
               retire, illegal, bus_err
    );
endinterface

// File: rtl/mc_control_fsm_decode.sv
// Combinational control decode: (state, opcode, funct, mem_ready) -> control
// vector, plus a legality flag for the current instruction.
module mc_control_fsm_decode
    import mc_control_fsm_pkg::*;
(
    input  state_t     state,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    output ctrl_t      ctrl,
    output logic       legal
);

    // Legality depends only on the instruction fields.
    always_comb begin
        legal = is_legal(opcode, funct);
    end

    // Per-state control vector; everything not named below stays 0.
    always_comb begin
        ctrl        = '0;
        ctrl.ext_op = 1'b1;
        case (state)
            ST_IF: begin
                ctrl.mem_read  = 1'b1;
                ctrl.ior_d     = 1'b0;
                ctrl.alu_src_a = SRCA_PC;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_source = PCSRC_ALU;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            ST_ID: begin
                // Branch target precomputed into ALUOut while decoding.
                ctrl.alu_src_a = SRCA_PC;
                ctrl.alu_src_b = SRCB_IMM_SH;
                ctrl.alu_op    = ALU_ADD;
                if (opcode == OP_J || opcode == OP_JAL) begin
                    ctrl.pc_write  = 1'b1;
                    ctrl.pc_source = PCSRC_JUMP;
                    ctrl.retire    = 1'b1;
                end
                if (opcode == OP_JAL) begin
                    // PC already holds PC+4, which is the link value.
                    ctrl.reg_write  = 1'b1;
                    ctrl.reg_dst    = DST_RA;
                    ctrl.mem_to_reg = M2R_PC;
                end
            end
            ST_EX: begin
                case (opcode)
                    OP_RTYPE: begin
                        if (funct == FN_JR || funct == FN_JALR) begin
                            ctrl.pc_write  = 1'b1;
                            ctrl.pc_source = PCSRC_REG;
                            ctrl.retire    = 1'b1;
                            if (funct == FN_JALR) begin
                                ctrl.reg_write  = 1'b1;
                                ctrl.reg_dst    = DST_RD;
                                ctrl.mem_to_reg = M2R_PC;
                            end
                        end else begin
                            ctrl.alu_src_a = is_shift(funct) ? SRCA_SHAMT : SRCA_REG;
                            ctrl.alu_src_b = SRCB_REG;
                            ctrl.alu_op    = ALU_FUNCT;
                        end
                    end
                    OP_ADDI, OP_ADDIU, OP_LUI, OP_LW, OP_SW: begin
                        ctrl.alu_src_a = SRCA_REG;
                        ctrl.alu_src_b = SRCB_IMM;
                        ctrl.alu_op    = ALU_ADD;
                        ctrl.lu_op     = (opcode == OP_LUI);
                    end
                    OP_ANDI: begin
                        ctrl.alu_src_a = SRCA_REG;
                        ctrl.alu_src_b = SRCB_IMM;
                        ctrl.alu_op    = ALU_AND;
                        ctrl.ext_op    = 1'b0;
                    end
                    OP_SLTI, OP_SLTIU: begin
                        ctrl.alu_src_a = SRCA_REG;
                        ctrl.alu_src_b = SRCB_IMM;
                        ctrl.alu_op    = (opcode == OP_SLTI) ? ALU_SLT : ALU_SLTU;
                    end
                    OP_BEQ: begin
                        ctrl.alu_src_a     = SRCA_REG;
                        ctrl.alu_src_b     = SRCB_REG;
                        ctrl.alu_op        = ALU_SUB;
                        ctrl.pc_write_cond = 1'b1;
                        ctrl.pc_source     = PCSRC_ALUOUT;
                        ctrl.retire        = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_MEM: begin
                ctrl.ior_d     = 1'b1;
                ctrl.mem_read  = (opcode == OP_LW);
                ctrl.mem_write = (opcode == OP_SW);
                ctrl.retire    = (opcode == OP_SW) && mem_ready;
            end
            ST_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.retire    = 1'b1;
                if (opcode == OP_RTYPE) begin
                    ctrl.reg_dst    = DST_RD;
                    ctrl.mem_to_reg = M2R_ALUOUT;
                end else if (opcode == OP_LW) begin
                    ctrl.reg_dst    = DST_RT;
                    ctrl.mem_to_reg = M2R_MDR;
                end else begin
                    ctrl.reg_dst    = DST_RT;
                    ctrl.mem_to_reg = M2R_ALUOUT;
                end
            end
            default: begin
                // ERR: everything idle.
                ctrl = '0;
            end
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS sequencer: state register, memory wait counter with
// timeout, sticky error flags, next-state logic. Outputs come from the decoder.
module mc_control_fsm
    import mc_control_fsm_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic             clk,
    input  logic             reset,
    mc_control_fsm_if.master bus,
    output state_t           dbg_state
);

    state_t             state;
    state_t             next_state;
    logic [CNT_W-1:0]   wait_cnt;
    logic               illegal_q;
    logic               bus_err_q;
    logic               waiting;
    logic               timeout_hit;
    logic               legal;
    ctrl_t              ctrl;
    logic               zero_unused;

    // zero is consumed by the datapath via PCWriteCond, not by the sequencer.
    assign zero_unused = bus.zero;

    mc_control_fsm_decode u_decode (
        .state     (state),
        .opcode    (bus.opcode),
        .funct     (bus.funct),
        .mem_ready (bus.mem_ready),
        .ctrl      (ctrl),
        .legal     (legal)
    );

    // A memory access is stalled; the timeout fires on the TIMEOUT_CYCLES-th such cycle.
    always_comb begin
        waiting     = ((state == ST_IF) || (state == ST_MEM)) && !bus.mem_ready;
        timeout_hit = (TIMEOUT_CYCLES != 0) && waiting &&
                      (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    end

    // Next-state selection.
    always_comb begin
        next_state = state;
        case (state)
            ST_IF: begin
                if (bus.mem_ready)    next_state = ST_ID;
                else if (timeout_hit) next_state = ST_ERR;
            end
            ST_ID: begin
                if (!legal)                                          next_state = ST_ERR;
                else if (bus.opcode == OP_J || bus.opcode == OP_JAL) next_state = ST_IF;
                else                                                 next_state = ST_EX;
            end
            ST_EX: begin
                if (bus.opcode == OP_RTYPE &&
                    (bus.funct == FN_JR || bus.funct == FN_JALR))       next_state = ST_IF;
                else if (bus.opcode == OP_BEQ)                          next_state = ST_IF;
                else if (bus.opcode == OP_LW || bus.opcode == OP_SW)    next_state = ST_MEM;
                else                                                    next_state = ST_WB;
            end
            ST_MEM: begin
                if (bus.mem_ready)    next_state = (bus.opcode == OP_LW) ? ST_WB : ST_IF;
                else if (timeout_hit) next_state = ST_ERR;
            end
            ST_WB:   next_state = ST_IF;
            ST_ERR:  next_state = ST_ERR;
            default: next_state = ST_ERR;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IF;
        else       state <= next_state;
    end

    // Wait counter: restarts on every state change, saturates while stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                         wait_cnt <= '0;
        else if (state != next_state)      wait_cnt <= '0;
        else if (waiting && wait_cnt != '1) wait_cnt <= wait_cnt + 1'b1;
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            if (state == ST_ID && !legal) illegal_q <= 1'b1;
            if (timeout_hit)              bus_err_q <= 1'b1;
        end
    end

    // Enables are masked by reset so they drop the moment reset rises.
    assign bus.PCWrite     = ctrl.pc_write      & ~reset;
    assign bus.PCWriteCond = ctrl.pc_write_cond & ~reset;
    assign bus.MemRead     = ctrl.mem_read      & ~reset;
    assign bus.MemWrite    = ctrl.mem_write     & ~reset;
    assign bus.IRWrite     = ctrl.ir_write      & ~reset;
    assign bus.RegWrite    = ctrl.reg_write     & ~reset;
    assign bus.retire      = ctrl.retire        & ~reset;
    assign bus.PCSource    = ctrl.pc_source;
    assign bus.IorD        = ctrl.ior_d;
    assign bus.RegDst      = ctrl.reg_dst;
    assign bus.MemtoReg    = ctrl.mem_to_reg;
    assign bus.ALUSrcA     = ctrl.alu_src_a;
    assign bus.ALUSrcB     = ctrl.alu_src_b;
    assign bus.ALUOp       = ctrl.alu_op;
    assign bus.ExtOp       = ctrl.ext_op;
    assign bus.LuOp        = ctrl.lu_op;
    assign bus.illegal     = illegal_q;
    assign bus.bus_err     = bus_err_q;
    assign dbg_state       = state;

endmodule
